// File: rtl/multi_edge_trap.sv
// ============================================================================
// multi_edge_trap
//
// Purpose:
//   This block brings NUM_CH asynchronous inputs into the clk domain.
//   It watches each channel for one edge type, chosen for all channels by
//   EDGE_MODE. Every qualified edge is reported in three ways:
//     * edge_pulse : a registered pulse that lasts one cycle
//     * trapped    : a sticky flag per channel, held until clear or reset
//     * count      : a saturating event counter per channel
//   A settle window runs after reset release. Until it ends, no edge is
//   reported, so an input that is already high when reset releases does
//   not look like a fresh rising edge.
//
// Parameters:
//   NUM_CH      number of independent channels (>= 1)
//   SYNC_STAGES synchroniser depth per channel (>= 2)
//   EDGE_MODE   0 = rising, 1 = falling, 2 = both
//   CNT_W       width of each event counter (>= 1)
//
// Ports:
//   clk          system clock; the only clock in the block
//   reset_n      asynchronous active-low reset
//   async_in     asynchronous inputs; bit i belongs to channel i
//   enable       global detection enable, synchronous to clk
//   clear        per-channel synchronous clear of trapped[i] and count i
//   edge_pulse   one-cycle pulse for each detected edge
//   trapped      sticky "edge seen since last clear/reset" flag per channel
//   count        saturating counters; channel i is [i*CNT_W +: CNT_W]
//   any_trapped  OR of all trapped bits
//   armed        high once the post-reset settle window has elapsed
// ============================================================================
module multi_edge_trap #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       async_in,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       clear,
    output logic [NUM_CH-1:0]       edge_pulse,
    output logic [NUM_CH-1:0]       trapped,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic                    any_trapped,
    output logic                    armed
);

    // The arm counter must be able to hold the value SYNC_STAGES.
    localparam int ARM_W = (SYNC_STAGES < 2) ? 2 : $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

    // Each event counter stops at its all-ones value.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Arm controller states. The block either waits out the settle window
    // or stays armed until the next reset.
    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_ARMED  = 1'b1;

    logic [0:0]       arm_state;
    logic [ARM_W-1:0] arm_cnt;

    // ------------------------------------------------------------------------
    // Arm window controller.
    // After reset_n rises, the block waits SYNC_STAGES+1 clock edges and then
    // arms. During that time the synchronisers fill with the true input
    // levels. The previous-value flops also catch up, so a level that was
    // already present at release never looks like a transition. The counter
    // counts one step per cycle. On the cycle it already holds SYNC_STAGES,
    // the controller moves to armed instead of counting again, which gives
    // exactly SYNC_STAGES+1 settle cycles.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_state <= ST_SETTLE;
            arm_cnt   <= '0;
        end else if (arm_state == ST_SETTLE) begin
            if (arm_cnt == ARM_LAST) begin
                arm_state <= ST_ARMED;
            end else begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end
    end

    assign armed = (arm_state == ST_ARMED);

    // ------------------------------------------------------------------------
    // Per-channel datapath. The channels share only enable and armed, so
    // each one is built as an independent slice.
    // ------------------------------------------------------------------------
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_s;
        logic                   prev_q;
        logic                   raw_edge;
        logic                   qual_edge;
        logic                   pulse_q;
        logic                   trap_q;
        logic [CNT_W-1:0]       cnt_q;

        // Synchroniser chain and previous-value flop.
        // Bit 0 of the chain samples the raw input. The top bit is the
        // synchronised level. The previous-value flop keeps the level from
        // one cycle earlier, so the pair shows a transition for exactly one
        // cycle. These flops keep tracking while the block is disabled or not
        // yet armed. As a result, an edge that was suppressed never turns up
        // later.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], async_in[ch]};
                prev_q <= sync_s;
            end
        end

        assign sync_s = sync_q[SYNC_STAGES-1];

        // The raw edge type is fixed at elaboration. Any mode value other
        // than 0 or 1 is treated as "both edges".
        if (EDGE_MODE == 0) begin : g_rise
            assign raw_edge = sync_s & ~prev_q;
        end else if (EDGE_MODE == 1) begin : g_fall
            assign raw_edge = ~sync_s & prev_q;
        end else begin : g_both
            assign raw_edge = sync_s ^ prev_q;
        end

        assign qual_edge = raw_edge & enable & armed;

        // Reporting registers.
        // The pulse is a registered copy of the qualified edge. Clear does not
        // affect it, so a consumer never loses an event it is waiting on.
        // For the sticky flag, a detection beats a clear in the same cycle,
        // so the newest event is never dropped. The counter follows the same
        // rule: clear plus edge loads 1, because that edge is the first one
        // after the clear. An edge on its own increments the counter but
        // holds at the maximum instead of wrapping.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pulse_q <= 1'b0;
                trap_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                pulse_q <= qual_edge;
                if (qual_edge) begin
                    trap_q <= 1'b1;
                    if (clear[ch]) begin
                        cnt_q <= CNT_W'(1);
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else if (clear[ch]) begin
                    trap_q <= 1'b0;
                    cnt_q  <= '0;
                end
            end
        end

        assign edge_pulse[ch]              = pulse_q;
        assign trapped[ch]                 = trap_q;
        assign count[ch*CNT_W +: CNT_W]    = cnt_q;
    end

    // Summary flag for a consumer that only needs to know whether anything
    // happened. It is built from the registered flags, so it is glitch-free.
    assign any_trapped = |trapped;

endmodule

// File: tb/tb_multi_edge_trap.sv
// ============================================================================
// tb_multi_edge_trap
//
// Drives three multi_edge_trap instances from shared stimulus:
//   A: rising edges,  SYNC_STAGES=2, CNT_W=8
//   B: both edges,    SYNC_STAGES=2, CNT_W=2
//   C: falling edges, SYNC_STAGES=3, CNT_W=3
// A behavioural model keeps the input level seen at every clock edge since
// reset. Each instance's expected outputs are derived from that history:
// the synchronised level at edge k is the input sampled at edge k-SYNC.
// ============================================================================
module tb_multi_edge_trap;

    localparam int NCH    = 4;
    localparam int A_MODE = 0, A_SYNC = 2, A_W = 8;
    localparam int B_MODE = 2, B_SYNC = 2, B_W = 2;
    localparam int C_MODE = 1, C_SYNC = 3, C_W = 3;
    localparam int HIST   = 4096;

    localparam int MODE_OF [3] = '{A_MODE, B_MODE, C_MODE};
    localparam int SYNC_OF [3] = '{A_SYNC, B_SYNC, C_SYNC};
    localparam int CMAX_OF [3] = '{(1 << A_W) - 1, (1 << B_W) - 1, (1 << C_W) - 1};

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic [NCH-1:0] async_in;
    logic [NCH-1:0] clear;

    logic [NCH-1:0]     a_pulse, a_trap, b_pulse, b_trap, c_pulse, c_trap;
    logic [NCH*A_W-1:0] a_cnt;
    logic [NCH*B_W-1:0] b_cnt;
    logic [NCH*C_W-1:0] c_cnt;
    logic a_any, a_armed, b_any, b_armed, c_any, c_armed;

    int vectors     = 0;
    int miscompares = 0;
    int b2_pulses   = 0;

    always #5 clk = ~clk;

    multi_edge_trap #(.NUM_CH(NCH), .SYNC_STAGES(A_SYNC), .EDGE_MODE(A_MODE), .CNT_W(A_W)) dut_a (
        .clk(clk), .reset_n(reset_n), .async_in(async_in), .enable(enable), .clear(clear),
        .edge_pulse(a_pulse), .trapped(a_trap), .count(a_cnt), .any_trapped(a_any), .armed(a_armed));

    multi_edge_trap #(.NUM_CH(NCH), .SYNC_STAGES(B_SYNC), .EDGE_MODE(B_MODE), .CNT_W(B_W)) dut_b (
        .clk(clk), .reset_n(reset_n), .async_in(async_in), .enable(enable), .clear(clear),
        .edge_pulse(b_pulse), .trapped(b_trap), .count(b_cnt), .any_trapped(b_any), .armed(b_armed));

    multi_edge_trap #(.NUM_CH(NCH), .SYNC_STAGES(C_SYNC), .EDGE_MODE(C_MODE), .CNT_W(C_W)) dut_c (
        .clk(clk), .reset_n(reset_n), .async_in(async_in), .enable(enable), .clear(clear),
        .edge_pulse(c_pulse), .trapped(c_trap), .count(c_cnt), .any_trapped(c_any), .armed(c_armed));

    // Reference model state.
    int          edge_num;
    logic [3:0]  hist [HIST];
    logic [3:0]  m_pulse [3];
    logic [3:0]  m_trap [3];
    int          m_cnt [3][4];
    logic        m_armed [3];

    // Input level sampled at clock edge j after reset release. Before the
    // first edge, the synchronisers hold zero.
    function automatic logic sampled(int j, int ch);
        if (j < 1 || j >= HIST) return 1'b0;
        return hist[j][ch];
    endfunction

    function automatic logic [31:0] packCount(int i, int w);
        logic [31:0] r;
        r = '0;
        for (int ch = 0; ch < NCH; ch++) r = r | (32'(m_cnt[i][ch]) << (ch * w));
        return r;
    endfunction

    // Behavioural model. At edge k, the synchronised level is the input seen
    // at edge k-SYNC, and the previous level is the input seen one edge
    // earlier. Edges are reported only once SYNC+1 edges have completed
    // since release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_num = 0;
            for (int i = 0; i < 3; i++) begin
                m_pulse[i] = '0;
                m_trap[i]  = '0;
                m_armed[i] = 1'b0;
                for (int ch = 0; ch < NCH; ch++) m_cnt[i][ch] = 0;
            end
        end else begin
            if (edge_num < HIST - 1) edge_num++;
            hist[edge_num] = async_in;
            for (int i = 0; i < 3; i++) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    logic now_v, before_v, raw, fire;
                    now_v    = sampled(edge_num - SYNC_OF[i], ch);
                    before_v = sampled(edge_num - SYNC_OF[i] - 1, ch);
                    case (MODE_OF[i])
                        0:       raw = now_v && !before_v;
                        1:       raw = !now_v && before_v;
                        default: raw = (now_v != before_v);
                    endcase
                    fire = raw && enable && (edge_num >= SYNC_OF[i] + 2);
                    m_pulse[i][ch] = fire;
                    if (fire) begin
                        m_trap[i][ch] = 1'b1;
                        if (clear[ch]) m_cnt[i][ch] = 1;
                        else if (m_cnt[i][ch] < CMAX_OF[i]) m_cnt[i][ch] = m_cnt[i][ch] + 1;
                    end else if (clear[ch]) begin
                        m_trap[i][ch] = 1'b0;
                        m_cnt[i][ch]  = 0;
                    end
                end
                m_armed[i] = (edge_num >= SYNC_OF[i] + 1);
            end
        end
    end

    task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compareInst(input string tag, input int i, input logic [3:0] pulse,
                               input logic [3:0] trap, input logic [31:0] cnt,
                               input logic any, input logic arm, input int w);
        compareValue({tag, ".pulse"}, 32'(pulse), 32'(m_pulse[i]));
        compareValue({tag, ".trapped"}, 32'(trap), 32'(m_trap[i]));
        compareValue({tag, ".count"}, cnt, packCount(i, w));
        compareValue({tag, ".any"}, 32'(any), 32'(|m_trap[i]));
        compareValue({tag, ".armed"}, 32'(arm), 32'(m_armed[i]));
    endtask

    task automatic checkOutput(input string tag);
        compareInst({tag, "/A"}, 0, a_pulse, a_trap, 32'(a_cnt), a_any, a_armed, A_W);
        compareInst({tag, "/B"}, 1, b_pulse, b_trap, 32'(b_cnt), b_any, b_armed, B_W);
        compareInst({tag, "/C"}, 2, c_pulse, c_trap, 32'(c_cnt), c_any, c_armed, C_W);
    endtask

    // Drives the inputs at the falling edge, then checks every instance one
    // time unit after each rising edge.
    task automatic applyStimulus(input logic [3:0] a, input logic en, input logic [3:0] clr,
                                 input int cycles, input string tag);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            async_in = a;
            enable   = en;
            clear    = clr;
            @(posedge clk);
            #1;
            checkOutput(tag);
            if (b_pulse[2]) b2_pulses++;
        end
    endtask

    initial begin
        logic [3:0] r_flip, r_clr;
        reset_n  = 1'b0;
        async_in = 4'b0010;
        enable   = 1'b1;
        clear    = 4'b0000;

        // Reset, with channel 1 held high through release.
        applyStimulus(4'b0010, 1'b1, 4'b0000, 2, "in_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_e1");
        applyStimulus(4'b0010, 1'b1, 4'b0000, 1, "settle_e2");
        compareValue("armed_low_e2", 32'(a_armed), 32'd0);
        applyStimulus(4'b0010, 1'b1, 4'b0000, 1, "settle_e3");
        compareValue("armed_high_e3", 32'(a_armed), 32'd1);
        compareValue("c_armed_low_e3", 32'(c_armed), 32'd0);
        applyStimulus(4'b0010, 1'b1, 4'b0000, 5, "idle");
        compareValue("ch1_no_trap", 32'(a_trap[1]), 32'd0);
        compareValue("ch1_count0", 32'(a_cnt[15:8]), 32'd0);

        // Rising edge on channel 0 is first sampled at P0 and pulses after P0+2.
        applyStimulus(4'b0011, 1'b1, 4'b0000, 2, "ch0_rise");
        compareValue("ch0_pulse_early", 32'(a_pulse[0]), 32'd0);
        applyStimulus(4'b0011, 1'b1, 4'b0000, 1, "ch0_rise_p2");
        compareValue("ch0_pulse_p2", 32'(a_pulse[0]), 32'd1);
        compareValue("ch0_count1", 32'(a_cnt[7:0]), 32'd1);
        applyStimulus(4'b0011, 1'b1, 4'b0000, 1, "ch0_rise_p3");
        compareValue("ch0_pulse_p3", 32'(a_pulse[0]), 32'd0);
        applyStimulus(4'b0011, 1'b1, 4'b0000, 3, "ch0_settle");

        // Five toggles on channel 2: instance B reports five edges and saturates at 3.
        b2_pulses = 0;
        for (int t = 0; t < 5; t++) begin
            applyStimulus(async_in ^ 4'b0100, 1'b1, 4'b0000, 4, "ch2_toggle");
        end
        applyStimulus(async_in, 1'b1, 4'b0000, 2, "ch2_settle");
        compareValue("b_ch2_pulses", 32'(b2_pulses), 32'd5);
        compareValue("b_ch2_saturated", 32'(b_cnt[5:4]), 32'd3);

        // Clear on channel 3 in the same cycle as the edge: the set wins.
        applyStimulus(async_in | 4'b1000, 1'b1, 4'b0000, 2, "ch3_rise");
        applyStimulus(async_in, 1'b1, 4'b1000, 1, "ch3_clear_and_edge");
        compareValue("ch3_pulse", 32'(a_pulse[3]), 32'd1);
        compareValue("ch3_trap_kept", 32'(a_trap[3]), 32'd1);
        compareValue("ch3_count1", 32'(a_cnt[31:24]), 32'd1);
        applyStimulus(async_in, 1'b1, 4'b0000, 4, "ch3_settle");
        applyStimulus(async_in, 1'b1, 4'b1000, 1, "ch3_clear_alone");
        compareValue("ch3_trap_cleared", 32'(a_trap[3]), 32'd0);
        compareValue("ch3_count_cleared", 32'(a_cnt[31:24]), 32'd0);
        applyStimulus(async_in, 1'b1, 4'b1111, 1, "clear_all");
        compareValue("a_any_cleared", 32'(a_any), 32'd0);
        compareValue("b_any_cleared", 32'(b_any), 32'd0);

        // Edge while disabled is never reported later.
        applyStimulus(async_in & 4'b1110, 1'b1, 4'b0000, 4, "ch0_fall");
        applyStimulus(async_in | 4'b0001, 1'b0, 4'b0000, 5, "ch0_rise_disabled");
        applyStimulus(async_in, 1'b1, 4'b0000, 4, "reenable");
        compareValue("ch0_no_trap", 32'(a_trap[0]), 32'd0);
        applyStimulus(async_in & 4'b1110, 1'b1, 4'b0000, 3, "ch0_fall2");
        applyStimulus(async_in | 4'b0001, 1'b1, 4'b0000, 4, "ch0_rise2");
        compareValue("ch0_count_after_enable", 32'(a_cnt[7:0]), 32'd1);

        // Bring channel 0 up to seven events, then reset in the middle of a cycle.
        for (int t = 0; t < 6; t++) begin
            applyStimulus(async_in & 4'b1110, 1'b1, 4'b0000, 3, "ch0_fall_n");
            applyStimulus(async_in | 4'b0001, 1'b1, 4'b0000, 3, "ch0_rise_n");
        end
        applyStimulus(async_in, 1'b1, 4'b0000, 1, "ch0_hold");
        compareValue("ch0_count7", 32'(a_cnt[7:0]), 32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_mid");
        compareValue("reset_mid_count0", 32'(a_cnt[7:0]), 32'd0);
        compareValue("reset_mid_pulse", 32'(a_pulse), 32'd0);
        applyStimulus(async_in, 1'b1, 4'b0000, 2, "reset_hold");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rerelease_e1");
        applyStimulus(async_in, 1'b1, 4'b0000, 1, "rerelease_e2");
        compareValue("rearm_low_e2", 32'(a_armed), 32'd0);
        applyStimulus(async_in, 1'b1, 4'b0000, 4, "rerelease");

        // Random phase: sparse toggles, occasional disable and clears.
        for (int n = 0; n < 400; n++) begin
            r_flip = 4'($urandom);
            if ($urandom_range(0, 2) != 0) r_flip = '0;
            r_clr = 4'($urandom);
            if ($urandom_range(0, 5) != 0) r_clr = '0;
            applyStimulus(async_in ^ r_flip, ($urandom_range(0, 7) != 0), r_clr, 1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
